// File: rtl/pe_pair_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// pe_pair_scheduler_pkg
// Shared types for the PE pair scheduler:
//   PARTICLE_ID_WIDTH  width of a particle id / home particle counter
//   pos_packet_t       neighbour position packet (x, y, z)
//   offset_packet_t    home particle offset packet read from the home cache
//   sched_state_t      scheduler FSM state, also exported on the debug port
// ---------------------------------------------------------------------------
package pe_pair_scheduler_pkg;

    localparam int PARTICLE_ID_WIDTH = 7;
    localparam int POS_W             = 25;
    localparam int OFFSET_W          = 27;

    typedef struct packed {
        logic [POS_W-1:0] pos_x;
        logic [POS_W-1:0] pos_y;
        logic [POS_W-1:0] pos_z;
    } pos_packet_t;

    typedef struct packed {
        logic [OFFSET_W-1:0] off_x;
        logic [OFFSET_W-1:0] off_y;
        logic [OFFSET_W-1:0] off_z;
    } offset_packet_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_NB = 3'd1,
        ISSUE   = 3'd2,
        FLUSH   = 3'd3,
        DONE    = 3'd4
    } sched_state_t;

endpackage

// File: rtl/pe_pair_scheduler.sv
// ---------------------------------------------------------------------------
// pe_pair_scheduler
// Sequences one PE: each neighbour particle accepted from the neighbour stream
// is issued paired with every home particle (ids 1..home_count) read from the
// home offset cache. Honours PE dispatch back-pressure and pulses done once a
// cell pair has completely left the output stage.
//
// Optional feature macro: PAIR_SCHED_STATS_EN
//   defined   -> pair_cnt / stall_cnt are saturating statistics counters
//   undefined -> pair_cnt / stall_cnt are tied to 0
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   start, home_count     begin a cell pair (IDLE only); home_count latched
//   nb_in, nb_in_valid,   neighbour stream; nb_in_last marks the cell's last
//   nb_in_last, nb_in_ready  neighbour
//   home_rd_en/addr/data  home cache read port, data valid 1 cycle after en
//   pe_home_offset(_valid), pe_nb_pos(_valid)  pair output to the PE
//   pe_back_pressure      PE almost-full; no new reads while high
//   busy, done            state != IDLE; 1-cycle completion pulse
//   pair_cnt, stall_cnt   statistics (see macro above)
//   dbg_state             current FSM state
//
// Handshake: a neighbour transfers on a clock edge where nb_in_valid and
// nb_in_ready are both high; nb_in_ready depends only on the registered state,
// never on nb_in_valid. The PE output has no ready; pe_back_pressure throttles
// new cache reads and at most the one already-read pair emerges afterwards.
// ---------------------------------------------------------------------------
module pe_pair_scheduler
    import pe_pair_scheduler_pkg::*;
#(
    parameter int ID_W     = PARTICLE_ID_WIDTH,
    parameter int MAX_HOME = 15,
    parameter int STAT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ID_W-1:0]   home_count,
    input  pos_packet_t       nb_in,
    input  logic              nb_in_valid,
    input  logic              nb_in_last,
    output logic              nb_in_ready,
    output logic              home_rd_en,
    output logic [ID_W-1:0]   home_rd_addr,
    input  offset_packet_t    home_rd_data,
    output offset_packet_t    pe_home_offset,
    output logic              pe_home_offset_valid,
    output pos_packet_t       pe_nb_pos,
    output logic              pe_nb_pos_valid,
    input  logic              pe_back_pressure,
    output logic              busy,
    output logic              done,
    output logic [STAT_W-1:0] pair_cnt,
    output logic [STAT_W-1:0] stall_cnt,
    output sched_state_t      dbg_state
);

    localparam logic [ID_W-1:0] MAX_HOME_ID = ID_W'(MAX_HOME);

    sched_state_t    state;
    logic [ID_W-1:0] hid;
    logic [ID_W-1:0] home_cnt_q;
    pos_packet_t     nb_q;
    logic            nb_last_q;
    logic            issue_rd;
    logic            out_valid;
    pos_packet_t     out_nb;

    // A read goes out in every ISSUE cycle the PE is not almost-full.
    assign issue_rd     = (state == ISSUE) && !pe_back_pressure;
    assign home_rd_en   = issue_rd;
    assign home_rd_addr = (state == ISSUE) ? hid : '0;
    assign nb_in_ready  = (state == WAIT_NB);
    assign busy         = (state != IDLE);
    assign done         = (state == DONE);
    assign dbg_state    = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            hid        <= '0;
            home_cnt_q <= '0;
            nb_q       <= '0;
            nb_last_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (home_count != '0) begin
                            home_cnt_q <= home_count;
                            state      <= WAIT_NB;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                WAIT_NB: begin
                    if (nb_in_valid) begin
                        nb_q      <= nb_in;
                        nb_last_q <= nb_in_last;
                        hid       <= ID_W'(1);
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!pe_back_pressure) begin
                        hid <= hid + 1'b1;
                        if (hid == home_cnt_q) begin
                            state <= nb_last_q ? FLUSH : WAIT_NB;
                        end
                    end
                end
                FLUSH:   state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Output stage. The cache's own output register is the data half of this
    // stage, so the offset is forwarded in the cycle after the read; valid and
    // the neighbour copy are registered alongside it. The neighbour is copied
    // per read so a neighbour accepted meanwhile cannot alter an in-flight pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_nb    <= '0;
        end else begin
            out_valid <= issue_rd;
            if (issue_rd) begin
                out_nb <= nb_q;
            end
        end
    end

    assign pe_home_offset_valid = out_valid;
    assign pe_nb_pos_valid      = out_valid;
    assign pe_nb_pos            = out_nb;
    assign pe_home_offset       = out_valid ? home_rd_data : '0;

`ifdef PAIR_SCHED_STATS_EN
    logic [STAT_W-1:0] pair_q;
    logic [STAT_W-1:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pair_q  <= '0;
            stall_q <= '0;
        end else begin
            if (issue_rd && (pair_q != '1)) begin
                pair_q <= pair_q + 1'b1;
            end
            if ((state == ISSUE) && pe_back_pressure && (stall_q != '1)) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

    assign pair_cnt  = pair_q;
    assign stall_cnt = stall_q;
`else
    assign pair_cnt  = '0;
    assign stall_cnt = '0;
`endif

`ifndef SYNTHESIS
    // hid does not wrap, so a cell pair larger than MAX_HOME is illegal.
    home_count_legal: assert property (@(posedge clk) disable iff (rst)
        ((state == IDLE) && start) |-> (home_count <= MAX_HOME_ID));
`endif

endmodule

// File: tb/tb_pe_pair_scheduler.sv
// ---------------------------------------------------------------------------
// tb_pe_pair_scheduler
// Directed bench for pe_pair_scheduler. A home cache model answers reads one
// cycle later; every accepted neighbour pushes its expected pairs
// ({nb_pos, home_offset} for ids 1..home_count) into exp_q, and a negedge
// monitor pops and compares each pair the DUT emits.
// ---------------------------------------------------------------------------
module tb_pe_pair_scheduler;
    import pe_pair_scheduler_pkg::*;

    localparam int ID_W   = PARTICLE_ID_WIDTH;
    localparam int STAT_W = 32;
    localparam int PAIR_W = $bits(pos_packet_t) + $bits(offset_packet_t);
    localparam int CW     = 160;
    typedef logic [CW-1:0] cw_t;

`ifdef PAIR_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              start;
    logic [ID_W-1:0]   home_count;
    pos_packet_t       nb_in;
    logic              nb_in_valid;
    logic              nb_in_last;
    logic              nb_in_ready;
    logic              home_rd_en;
    logic [ID_W-1:0]   home_rd_addr;
    offset_packet_t    home_rd_data;
    offset_packet_t    pe_home_offset;
    logic              pe_home_offset_valid;
    pos_packet_t       pe_nb_pos;
    logic              pe_nb_pos_valid;
    logic              pe_back_pressure;
    logic              busy;
    logic              done;
    logic [STAT_W-1:0] pair_cnt;
    logic [STAT_W-1:0] stall_cnt;
    sched_state_t      dbg_state;

    pe_pair_scheduler #(.ID_W(ID_W), .MAX_HOME(15), .STAT_W(STAT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .home_count(home_count),
        .nb_in(nb_in), .nb_in_valid(nb_in_valid), .nb_in_last(nb_in_last),
        .nb_in_ready(nb_in_ready), .home_rd_en(home_rd_en),
        .home_rd_addr(home_rd_addr), .home_rd_data(home_rd_data),
        .pe_home_offset(pe_home_offset), .pe_home_offset_valid(pe_home_offset_valid),
        .pe_nb_pos(pe_nb_pos), .pe_nb_pos_valid(pe_nb_pos_valid),
        .pe_back_pressure(pe_back_pressure), .busy(busy), .done(done),
        .pair_cnt(pair_cnt), .stall_cnt(stall_cnt), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset / cycle counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [PAIR_W-1:0] exp_q[$];
    int pairs_seen = 0;
    int done_cnt = 0;
    int bp_valids = 0;
    int last_rd_cyc = 0;
    int first_valid_cyc = 0;
    int acc_cyc = 0;
    bit seen_valid = 1'b0;
    bit ready_seen = 1'b0;

    task automatic check(input string tag, input cw_t obs, input cw_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic offset_packet_t home_off(input logic [ID_W-1:0] id);
        offset_packet_t o;
        o.off_x = 27'(id) * 27'd3 + 27'h100;
        o.off_y = {20'h5A5A5, id};
        o.off_z = ~27'(id);
        return o;
    endfunction

    // Home cache model: one-cycle read latency.
    always @(posedge clk) begin
        if (home_rd_en) home_rd_data <= home_off(home_rd_addr);
    end

    // Output monitor, sampled away from the active edge.
    always @(negedge clk) begin
        logic [PAIR_W-1:0] exp_pair;
        if (home_rd_en) last_rd_cyc = cyc;
        if (done) done_cnt++;
        if (nb_in_ready) ready_seen = 1'b1;
        if (pe_back_pressure && pe_home_offset_valid) bp_valids++;
        if (pe_home_offset_valid) begin
            pairs_seen++;
            if (!seen_valid) begin
                seen_valid = 1'b1;
                first_valid_cyc = cyc;
            end
            check("nb_valid_matches", cw_t'(pe_nb_pos_valid), cw_t'(1));
            check("pair_expected", cw_t'(exp_q.size() != 0), cw_t'(1));
            if (exp_q.size() != 0) begin
                exp_pair = exp_q.pop_front();
                check("sb_pair", cw_t'({pe_nb_pos, pe_home_offset}), cw_t'(exp_pair));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pair(input int hc);
        home_count = ID_W'(hc);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_nb(input pos_packet_t pos, input logic last, input int hc);
        bit found = 1'b0;
        nb_in = pos;
        nb_in_last = last;
        nb_in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (nb_in_ready) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check("nb_accept", cw_t'(found), cw_t'(1));
        if (found) begin
            for (int id = 1; id <= hc; id++) begin
                exp_q.push_back({pos, home_off(ID_W'(id))});
            end
            acc_cyc = cyc;
        end
        step();
        nb_in_valid = 1'b0;
        nb_in_last = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check(tag, cw_t'(found), cw_t'(1));
    endtask

    function automatic pos_packet_t mk_pos(input logic [24:0] x, input logic [24:0] y,
                                           input logic [24:0] z);
        pos_packet_t p;
        p.pos_x = x;
        p.pos_y = y;
        p.pos_z = z;
        return p;
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        int p0;
        int d0;
        logic [24:0] rnd;

        rst = 1'b1;
        start = 1'b0;
        home_count = '0;
        nb_in = '0;
        nb_in_valid = 1'b0;
        nb_in_last = 1'b0;
        pe_back_pressure = 1'b0;
        repeat (3) step();

        // Reset state
        check("rst_busy", cw_t'(busy), cw_t'(0));
        check("rst_done", cw_t'(done), cw_t'(0));
        check("rst_ready", cw_t'(nb_in_ready), cw_t'(0));
        check("rst_rd_en", cw_t'({home_rd_en, home_rd_addr}), cw_t'(0));
        check("rst_valids", cw_t'({pe_home_offset_valid, pe_nb_pos_valid}), cw_t'(0));
        check("rst_data", cw_t'({pe_nb_pos, pe_home_offset}), cw_t'(0));
        check("rst_stats", cw_t'({pair_cnt, stall_cnt}), cw_t'(0));
        check("rst_state", cw_t'(dbg_state), cw_t'(IDLE));
        rst = 1'b0;
        step();

        // 1: 15 home particles, two neighbours, no back-pressure
        p0 = pairs_seen;
        d0 = done_cnt;
        start_pair(15);
        check("t1_busy", cw_t'(busy), cw_t'(1));
        rnd = 25'($urandom_range(0, 32'h1FFFFFF));
        send_nb(mk_pos(25'h0123456, rnd, 25'h1ABCDEF), 1'b0, 15);
        send_nb(mk_pos(25'h0FEDCBA, 25'h0000001, rnd), 1'b1, 15);
        wait_done("t1_done_seen");
        check("t1_done_latency", cw_t'(cyc - last_rd_cyc), cw_t'(2));
        step();
        check("t1_done_pulse", cw_t'({done, busy}), cw_t'(0));
        check("t1_pairs", cw_t'(pairs_seen - p0), cw_t'(30));
        check("t1_done_count", cw_t'(done_cnt - d0), cw_t'(1));
        check("t1_queue_empty", cw_t'(exp_q.size()), cw_t'(0));

        // 2: 4 home particles, one neighbour, latency to first pair
        p0 = pairs_seen;
        seen_valid = 1'b0;
        start_pair(4);
        send_nb(mk_pos(25'h1080000, 25'h0040000, 25'h0000777), 1'b1, 4);
        wait_done("t2_done_seen");
        step();
        check("t2_first_latency", cw_t'(first_valid_cyc - acc_cyc), cw_t'(2));
        check("t2_pairs", cw_t'(pairs_seen - p0), cw_t'(4));
        check("t2_queue_empty", cw_t'(exp_q.size()), cw_t'(0));

        // 3: back-pressure for 5 cycles in the middle of ISSUE
        p0 = pairs_seen;
        start_pair(15);
        send_nb(mk_pos(25'h0333333, 25'h0444444, 25'h0555555), 1'b1, 15);
        step();
        step();
        bp_valids = 0;
        pe_back_pressure = 1'b1;
        repeat (5) step();
        check("t3_valids_after_bp", cw_t'(bp_valids), cw_t'(1));
        check("t3_hid_held", cw_t'({home_rd_en, home_rd_addr}), cw_t'(3));
        pe_back_pressure = 1'b0;
        wait_done("t3_done_seen");
        step();
        check("t3_pairs", cw_t'(pairs_seen - p0), cw_t'(15));
        check("t3_queue_empty", cw_t'(exp_q.size()), cw_t'(0));
        check("t3_stall_cnt", cw_t'(stall_cnt), cw_t'(STATS ? 5 : 0));
        check("t3_pair_cnt", cw_t'(pair_cnt), cw_t'(STATS ? 49 : 0));

        // 4: home_count == 0 with a neighbour waiting that must not be taken
        p0 = pairs_seen;
        ready_seen = 1'b0;
        nb_in = mk_pos(25'h1555555, 25'h0AAAAAA, 25'h0000042);
        nb_in_valid = 1'b1;
        nb_in_last = 1'b1;
        start_pair(0);
        check("t4_done", cw_t'({done, busy}), cw_t'(3));
        step();
        check("t4_done_cleared", cw_t'({done, busy}), cw_t'(0));
        repeat (3) step();
        check("t4_never_ready", cw_t'(ready_seen), cw_t'(0));
        check("t4_no_pairs", cw_t'(pairs_seen - p0), cw_t'(0));
        nb_in_valid = 1'b0;
        nb_in_last = 1'b0;
        step();

        // 5: reset while issuing home id 7
        start_pair(10);
        send_nb(mk_pos(25'h0707070, 25'h0101010, 25'h0202020), 1'b1, 10);
        begin
            bit found = 1'b0;
            for (int i = 0; i < 50; i++) begin
                if (home_rd_en && (home_rd_addr == ID_W'(7))) begin
                    found = 1'b1;
                    break;
                end
                step();
            end
            check("t5_reach_hid7", cw_t'(found), cw_t'(1));
        end
        rst = 1'b1;
        d0 = done_cnt;
        step();
        exp_q.delete();
        check("t5_busy", cw_t'(busy), cw_t'(0));
        check("t5_valids", cw_t'({pe_home_offset_valid, pe_nb_pos_valid}), cw_t'(0));
        check("t5_state", cw_t'(dbg_state), cw_t'(IDLE));
        check("t5_stats_cleared", cw_t'({pair_cnt, stall_cnt}), cw_t'(0));
        rst = 1'b0;
        repeat (4) step();
        check("t5_no_done", cw_t'(done_cnt - d0), cw_t'(0));
        p0 = pairs_seen;
        start_pair(3);
        send_nb(mk_pos(25'h0ABCDEF, 25'h0012345, 25'h1000001), 1'b1, 3);
        wait_done("t5_restart_done");
        step();
        check("t5_restart_pairs", cw_t'(pairs_seen - p0), cw_t'(3));
        check("t5_pair_cnt", cw_t'(pair_cnt), cw_t'(STATS ? 3 : 0));

        // 6: start pulsed while busy is ignored
        p0 = pairs_seen;
        start_pair(5);
        home_count = ID_W'(2);
        start = 1'b1;
        step();
        start = 1'b0;
        check("t6_state", cw_t'(dbg_state), cw_t'(WAIT_NB));
        send_nb(mk_pos(25'h0606060, 25'h0060606, 25'h1606060), 1'b1, 5);
        wait_done("t6_done_seen");
        step();
        check("t6_pairs", cw_t'(pairs_seen - p0), cw_t'(5));
        check("t6_queue_empty", cw_t'(exp_q.size()), cw_t'(0));

        repeat (3) step();
        check("final_queue_empty", cw_t'(exp_q.size()), cw_t'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
